// File: rtl/regf_wb_arb.sv
// Register-file port C write-back arbiter: ALU results first, then queued loads, then bypassed loads.
// Latency: 1 cycle from selection to registered wec/addrc/datac.
// Backpressure: mem_ready drops when the load FIFO is full; a return presented then is dropped and flagged.
module regf_wb_arb #(
    parameter int WIDTH  = 5,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              halt,
    input  logic              flush_pipeline,
    input  logic              alu_we,
    input  logic [WIDTH-1:0]  alu_addr,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic              mem_we,
    input  logic [WIDTH-1:0]  mem_addr,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              mem_ready,
    output logic              wec,
    output logic [WIDTH-1:0]  addrc,
    output logic [DWIDTH-1:0] datac,
    output logic              wb_idle,
    output logic              overflow
);

    // DEPTH must be a power of two so the pointers wrap by natural overflow.
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] L_ONE  = (AW + 1)'(1);

    logic [AW:0]        r_count;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [WIDTH-1:0]   r_q_addr [DEPTH];
    logic [DWIDTH-1:0]  r_q_data [DEPTH];
    logic               r_wec;
    logic [WIDTH-1:0]   r_addrc;
    logic [DWIDTH-1:0]  r_datac;
    logic               r_overflow;

    logic               w_empty;
    logic               w_run;
    logic               w_accept;
    logic               w_sel_alu;
    logic               w_sel_head;
    logic               w_sel_byp;
    logic               w_enq;
    logic               w_deq;
    logic [WIDTH-1:0]   w_wb_addr;
    logic [DWIDTH-1:0]  w_wb_data;

    assign w_empty   = (r_count == '0);
    assign mem_ready = (r_count != L_FULL);

    always_comb begin
        w_run      = ~halt & ~flush_pipeline;
        w_accept   = mem_we & mem_ready & ~flush_pipeline;
        w_sel_alu  = w_run & alu_we;
        w_sel_head = w_run & ~alu_we & ~w_empty;
        // Bypass only with an empty FIFO so loads never overtake queued ones.
        w_sel_byp  = w_run & ~alu_we & w_empty & w_accept;
        w_enq      = w_accept & ~w_sel_byp;
        w_deq      = w_sel_head;
        w_wb_addr  = mem_addr;
        w_wb_data  = mem_data;
        if (w_sel_alu) begin
            w_wb_addr = alu_addr;
            w_wb_data = alu_data;
        end else if (w_sel_head) begin
            w_wb_addr = r_q_addr[r_rd_ptr];
            w_wb_data = r_q_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_wec      <= 1'b0;
            r_addrc    <= '0;
            r_datac    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_pipeline) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_wec      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq && !w_deq) begin
                r_count <= r_count + L_ONE;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - L_ONE;
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (mem_we && !mem_ready) begin
                r_overflow <= 1'b1;
            end
            r_wec <= w_sel_alu | w_sel_head | w_sel_byp;
            if (w_sel_alu || w_sel_head || w_sel_byp) begin
                r_addrc <= w_wb_addr;
                r_datac <= w_wb_data;
            end
        end
    end

    // Storage needs no reset: entries are only read below r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_addr[r_wr_ptr] <= mem_addr;
            r_q_data[r_wr_ptr] <= mem_data;
        end
    end

    assign wec      = r_wec;
    assign addrc    = r_addrc;
    assign datac    = r_datac;
    assign overflow = r_overflow;
    assign wb_idle  = w_empty & ~r_wec;

    a_no_alu_in_halt: assert property (@(posedge clk) disable iff (!reset_b)
        !(halt && alu_we && !flush_pipeline));

endmodule

// File: doc/regf_wb_arb.md
# regf_wb_arb

Port C write-back arbiter for the register file. It merges fixed-latency ALU results with variable-latency memory load returns into a single registered write port: wec, addrc and datac. That port drives both the register file and the scoreboard's write-back clear. Load returns that lose arbitration are held in a small FIFO, so the memory unit never has to retry a return it has already presented.

## Interface
Parameters:
- WIDTH, 5: register address width.
- DWIDTH, 32: register data width.
- DEPTH, 4: load-return FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk, input, 1: system clock. Rising edge.
- reset_b, input, 1: asynchronous, active-low reset.
- halt, input, 1: system stall. No write-back is issued while high.
- flush_pipeline, input, 1: pipeline flush. Discards all pending write-backs.
- alu_we, input, 1: ALU result valid this cycle.
- alu_addr, input, WIDTH: ALU destination register.
- alu_data, input, DWIDTH: ALU result.
- mem_we, input, 1: load return valid this cycle.
- mem_addr, input, WIDTH: load destination register.
- mem_data, input, DWIDTH: load data.
- mem_ready, output, 1: a load return is accepted this cycle.
- wec, output, 1: port C write enable, registered.
- addrc, output, WIDTH: port C address, registered.
- datac, output, DWIDTH: port C data, registered.
- wb_idle, output, 1: FIFO empty and wec low.
- overflow, output, 1: sticky flag. A load return was presented while mem_ready was low.

## Operation
- **Selection priority.** Each cycle with halt and flush_pipeline low, the source is chosen in this order:
  1. ALU, if alu_we.
  2. FIFO head, if the FIFO is non-empty.
  3. Load input, bypassing the FIFO, if mem_we and mem_ready.
  4. Otherwise no write.
- **Enqueue.** A load return is enqueued when mem_we & mem_ready and it is not the bypassed source.
  - The FIFO head and the bypass are mutually exclusive. Bypass happens only when the FIFO is empty, which preserves load order.
- **Simultaneous events.** Enqueue and dequeue in the same cycle leaves count unchanged. The head is popped and the new entry is written at the tail.
- **mem_ready.** mem_ready = (count != DEPTH), using the registered count.
  - A return arriving with mem_ready low is dropped and sets overflow.
  - overflow clears only on reset or flush_pipeline.
- **halt.**
  - wec is driven 0 and the FIFO does not dequeue.
  - Load returns still enqueue while mem_ready is high; bypass is disabled.
  - alu_we must be 0 during halt because the ALU stage is frozen. If alu_we is asserted during halt, the ALU write is ignored and a simulation assertion fires.
- **flush_pipeline.** Takes priority over halt and over all inputs.
  - Clears count and the read/write pointers.
  - Clears overflow.
  - Registers wec = 0.
  - Inputs presented in the flush cycle are discarded.
  - This matches the scoreboard clearing its status on the same flush.
- **Register ordering.** The scoreboard guarantees at most one outstanding writer per register. The arbiter therefore applies no same-address ordering between ALU and FIFO entries. Within the load stream, order is strictly FIFO.
- **FIFO implementation.**
  - Read/write pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - A separate count of log2(DEPTH)+1 bits distinguishes full from empty.
- **wb_idle.** wb_idle = (count == 0) & !wec. Context-switch logic uses it together with the scoreboard's safe_switch.

## Timing
- **Reset values.** wec = 0, addrc = 0, datac = 0, overflow = 0, count = 0, mem_ready = 1, wb_idle = 1.
- **Latency.** Selection in cycle N gives wec/addrc/datac valid in cycle N+1.
  - ALU write: input cycle to port C, 1 cycle.
  - Bypassed load: 1 cycle.
  - Queued load: 1 cycle after the first cycle with no ALU write, no halt and it at the head.
- **Deassertion.** wec is high for exactly one cycle per write. There is no hold.
- **mem_ready timing.** mem_ready updates the cycle after the count change. In the full cycle itself, a dequeue does not re-enable acceptance until the next cycle.
- **Reset mid-operation.** Asynchronous reset immediately forces all reset values. FIFO contents become don't-care, and no partial write is issued.
- **Pointer wrap.** Wrap at DEPTH-1 → 0 introduces no bubble.

## Test plan
- **ALU only.** alu_we=1, alu_addr=5, alu_data=32'h1234 in cycle 0 → wec=1, addrc=5, datac=32'h1234 in cycle 1 only.
- **Collision.** alu_we (addr 3) and mem_we (addr 7, data 32'hA5) in cycle 0, nothing after → cycle 1 writes r3, cycle 2 writes r7 from the FIFO, wb_idle=1 in cycle 3.
- **Fill and overflow (DEPTH=4).**
  - Stimulus: alu_we held high; loads to r1..r4, then r5.
  - Required: mem_ready falls after the 4th load; the r5 return is dropped and overflow=1.
  - Then release alu_we: r1, r2, r3, r4 are written in order on consecutive cycles, and mem_ready returns high one cycle after the first pop.
- **Wrap.** Ten interleaved enqueue/dequeue sequences across the pointer wrap → all loads are written in order with none lost or duplicated.
- **halt.** halt=1 for 3 cycles with 2 loads arriving → wec=0 throughout halt. After halt drops, both loads are written in the first 2 cycles.
- **flush.** flush_pipeline with 3 queued entries and overflow=1 → next cycle count=0, wec=0, overflow=0, mem_ready=1, and no queued entry is ever written.
